drygascon128_absorb_ctrl: RTL
=============================

// Module: drygascon128_absorb_ctrl
// PURPOSE
// - Upstream sequencer for the drygascon128 F/G core.
// - Accepts a byte-aligned message as a 32-bit stream, splits it into 128-bit blocks and applies 10* padding.
// - For each block it drives the core's word-serial interface: wr_i x4, then start. It waits for idle.
// - After the final block it reads the 128-bit rate r and presents it downstream as 4 words.
// - Key/state load (wr_c, wr_x) is out of scope and is done before the first message.
// PARAMETERS
// - F_ROUNDS  7  value driven on core_rounds (4 bits, 1..15)
// PORTS
// - clk         in   1   clock
// - rst         in   1   sync active-high reset; also drives the core's rst
// - cfg_domain  in   2   domain bits, sampled with the first accepted word of a message
// - s_data      in   32  message word, little-endian: byte0 = [7:0]
// - s_bytes     in   3   valid bytes in s_data (0..4); only 4 allowed unless s_last
// - s_last      in   1   final word of message
// - s_valid     in   1   input word valid
// - s_ready     out  1   input word accepted when s_valid & s_ready
// - m_data      out  32  r word, r[32k+:32] for k=0..3
// - m_last      out  1   high with word k=3
// - m_valid     out  1   output valid; m_data/m_last held stable until m_ready
// - m_ready     in   1   downstream accept
// - core_din    out  32  to core din
// - core_ds     out  4   to core ds = {domain[1:0], final, padded}
// - core_wr_i   out  1   to core wr_i
// - core_rounds out  4   = F_ROUNDS
// - core_start  out  1   to core start
// - core_rd_r   out  1   to core rd_r
// - core_dout   in   32  from core dout (registered; valid 1 cycle after rd_r)
// - core_idle   in   1   from core idle
// - busy        out  1   high in any state but FILL with buffer index 0
// BEHAVIOUR
// - Reset:
//   - Reset drives the state machine to FILL with buffer index 0.
//   - All outputs reset to 0; s_ready resets to 1.
//   - The core's clk_en is tied high. core_wr_c, core_wr_x and core_rd_c are tied 0.
// - State machine: FILL -> WRITE -> START -> WAIT -> BUSY -> (final ? READ -> OUT : FILL).
// - FILL:
//   - s_ready=1. An accepted word is stored in buf[idx] and idx increments.
//   - Block complete at idx==3 accept: final=s_last, padded=0.
//   - When s_last arrives with bytes<4, or with bytes==4 at idx<3:
//     - Write byte 0x01 at the first free byte position; zero the rest of the buffer.
//     - Set final=1, padded=1.
//     - This takes 0 extra cycles; the pad is inserted combinationally at accept.
//   - s_last with bytes==4 at idx==3: final=1, padded=0. No extra block.
//   - Empty message (first word s_last, bytes=0): block = 0x01 followed by 15 zero bytes, padded=1.
// - WRITE:
//   - 4 cycles, s_ready=0.
//   - Each cycle: core_wr_i=1, core_din=buf[k] for k=0..3, core_ds valid and held until START ends.
// - START: 1 cycle core_start=1. WAIT: 1 cycle, absorbs the core idle deassert latency.
// - BUSY: wait for core_idle==1, then go to READ if final, else to FILL with idx=0.
// - READ: core_rd_r=1 for 4 consecutive cycles. core_dout is captured 1 cycle later into obuf[0..3].
// - OUT:
//   - m_valid=1; words are presented k=0..3, with m_last on k=3.
//   - m_valid & m_ready advances k. After k=3 is accepted, go to FILL with idx=0.
// - Backpressure:
//   - s_valid low in FILL stalls with no timeout.
//   - m_ready low holds the word indefinitely.
// - Latency: last block accept -> first m_valid = 4 + 1 + 1 + core F time (about F_ROUNDS+3 cycles) + 5.
// - Simultaneous events:
//   - core_idle is ignored outside BUSY.
//   - s_valid is ignored outside FILL.
// - rst mid-operation: controller and core both reset. Any partial block and pending output are discarded.
// TESTING
// - 16-byte msg 00..0F, domain=1:
//   - Expect 4 wr_i with din 03020100, 07060504, 0B0A0908, 0F0E0D0C.
//   - Expect ds=4'b0110 and one start.
//   - Expect 4 m words with m_last on the 4th.
// - Empty msg, domain=0 -> din 00000001,0,0,0; ds=4'b0011; one F; 4 output words.
// - 5-byte msg AA BB CC DD EE -> din DDCCBBAA, 000001EE, 0, 0; ds padded=1, final=1.
// - 20-byte msg:
//   - Expect 2 F calls: the first with ds final=0,padded=0, the second with word0=last word, word1=00000001.
//   - Expect s_ready=0 between the two blocks.
// - m_ready held 0 for 10 cycles on word 1 -> m_data stable, no word lost or repeated; s_ready stays 0.
// - rst asserted in BUSY -> next cycle state FILL, s_ready=1, m_valid=0; a following 4-byte msg completes normally.

Source files
------------

// File: rtl/drygascon128_absorb_ctrl_if.sv
// Bundle between the drygascon128 absorb sequencer, its message source/sink and the F/G core.
// The master modport is the sequencer side; slave is the environment (source, sink and core).
interface drygascon128_absorb_ctrl_if;
  logic [1:0]  cfg_domain;
  logic [31:0] s_data;
  logic [2:0]  s_bytes;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] core_din;
  logic [3:0]  core_ds;
  logic        core_wr_i;
  logic [3:0]  core_rounds;
  logic        core_start;
  logic        core_rd_r;
  logic [31:0] core_dout;
  logic        core_idle;
  logic        core_rst;
  logic        core_clk_en;
  logic        core_wr_c;
  logic        core_wr_x;
  logic        core_rd_c;
  logic        busy;

  modport master (
    input  cfg_domain, s_data, s_bytes, s_last, s_valid, m_ready, core_dout, core_idle,
    output s_ready, m_data, m_last, m_valid, core_din, core_ds, core_wr_i, core_rounds,
    output core_start, core_rd_r, core_rst, core_clk_en, core_wr_c, core_wr_x, core_rd_c, busy
  );

  modport slave (
    output cfg_domain, s_data, s_bytes, s_last, s_valid, m_ready, core_dout, core_idle,
    input  s_ready, m_data, m_last, m_valid, core_din, core_ds, core_wr_i, core_rounds,
    input  core_start, core_rd_r, core_rst, core_clk_en, core_wr_c, core_wr_x, core_rd_c, busy
  );
endinterface

// File: rtl/drygascon128_absorb_ctrl.sv
// Message absorb sequencer for the drygascon128 core: packs a 32-bit byte stream into padded
// 128-bit blocks, runs one F call per block and streams the final rate r out as four words.
module drygascon128_absorb_ctrl #(
  parameter logic [3:0] F_ROUNDS = 4'd7
) (
  input logic clk,
  input logic rst,
  drygascon128_absorb_ctrl_if.master bus
);

  typedef enum logic [2:0] {FILL, WRITE, START, WAIT, BUSY, READ, OUT} state_t;

  state_t           state_q;
  logic [3:0][31:0] buf_q;
  logic [3:0][31:0] obuf_q;
  logic [1:0]       idx_q;
  logic [1:0]       wcnt_q;
  logic [1:0]       ocnt_q;
  logic [1:0]       kcnt_q;
  logic             cap_q;
  logic             final_q;
  logic [1:0]       dom_q;
  logic             msg_start_q;

  logic             s_ready_q;
  logic             m_valid_q;
  logic             m_last_q;
  logic [31:0]      m_data_q;
  logic [31:0]      din_q;
  logic [3:0]       ds_q;
  logic             wr_q;
  logic             start_q;
  logic             rd_q;

  logic [2:0]       eff_bytes_d;
  logic             pad_d;
  logic             spill_pad_d;
  logic             blk_done_d;
  logic [1:0]       dom_d;
  logic [31:0]      tail_word_d;
  logic [3:0][31:0] blk_d;
  logic             accept_d;

  // Non-final words always count as full; s_bytes only matters on the last word.
  assign eff_bytes_d = (bus.s_last && (bus.s_bytes < 3'd4)) ? bus.s_bytes : 3'd4;
  assign pad_d       = bus.s_last && ((eff_bytes_d != 3'd4) || (idx_q != 2'd3));
  assign spill_pad_d = bus.s_last && (eff_bytes_d == 3'd4) && (idx_q != 2'd3);
  assign blk_done_d  = (idx_q == 2'd3) || bus.s_last;
  assign dom_d       = msg_start_q ? bus.cfg_domain : dom_q;
  assign accept_d    = bus.s_valid && s_ready_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    localparam logic [2:0] BI = 3'(gi);
    assign tail_word_d[8*gi +: 8] = (BI < eff_bytes_d) ? bus.s_data[8*gi +: 8] :
                                    (BI == eff_bytes_d) ? 8'h01 : 8'h00;
  end

  // Block as it would look after this accept: earlier words kept, pad inserted, tail zeroed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    localparam logic [1:0] WI = 2'(gi);
    assign blk_d[gi] = (WI < idx_q)  ? buf_q[gi] :
                       (WI == idx_q) ? tail_word_d :
                       (spill_pad_d && (WI == idx_q + 2'd1)) ? 32'h0000_0001 : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      buf_q       <= '0;
      obuf_q      <= '0;
      idx_q       <= 2'd0;
      wcnt_q      <= 2'd0;
      ocnt_q      <= 2'd0;
      kcnt_q      <= 2'd0;
      cap_q       <= 1'b0;
      final_q     <= 1'b0;
      dom_q       <= 2'd0;
      msg_start_q <= 1'b1;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= 32'h0;
      din_q       <= 32'h0;
      ds_q        <= 4'h0;
      wr_q        <= 1'b0;
      start_q     <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      // core_dout is valid one cycle after each rd_r pulse.
      cap_q <= rd_q;
      if (cap_q) begin
        obuf_q[ocnt_q] <= bus.core_dout;
        ocnt_q         <= ocnt_q + 2'd1;
      end

      case (state_q)
        FILL: begin
          if (accept_d) begin
            buf_q <= blk_d;
            if (msg_start_q) begin
              dom_q       <= bus.cfg_domain;
              msg_start_q <= 1'b0;
            end
            if (blk_done_d) begin
              s_ready_q <= 1'b0;
              wr_q      <= 1'b1;
              din_q     <= blk_d[0];
              ds_q      <= {dom_d, bus.s_last, pad_d};
              final_q   <= bus.s_last;
              wcnt_q    <= 2'd1;
              state_q   <= WRITE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        WRITE: begin
          if (wcnt_q == 2'd0) begin
            wr_q    <= 1'b0;
            start_q <= 1'b1;
            state_q <= START;
          end else begin
            din_q  <= buf_q[wcnt_q];
            wcnt_q <= wcnt_q + 2'd1;
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: state_q <= BUSY;
        BUSY: begin
          if (bus.core_idle) begin
            if (final_q) begin
              rd_q    <= 1'b1;
              wcnt_q  <= 2'd1;
              ocnt_q  <= 2'd0;
              state_q <= READ;
            end else begin
              idx_q     <= 2'd0;
              s_ready_q <= 1'b1;
              state_q   <= FILL;
            end
          end
        end
        READ: begin
          if (rd_q) begin
            if (wcnt_q == 2'd0) rd_q <= 1'b0;
            else                wcnt_q <= wcnt_q + 2'd1;
          end
          // Word 0 was captured three cycles earlier, so it can be presented now.
          if (cap_q && (ocnt_q == 2'd3)) begin
            m_valid_q <= 1'b1;
            m_data_q  <= obuf_q[0];
            m_last_q  <= 1'b0;
            kcnt_q    <= 2'd0;
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            if (kcnt_q == 2'd3) begin
              m_valid_q   <= 1'b0;
              m_last_q    <= 1'b0;
              idx_q       <= 2'd0;
              s_ready_q   <= 1'b1;
              msg_start_q <= 1'b1;
              state_q     <= FILL;
            end else begin
              kcnt_q   <= kcnt_q + 2'd1;
              m_data_q <= obuf_q[kcnt_q + 2'd1];
              m_last_q <= (kcnt_q == 2'd2);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_last      = m_last_q;
  assign bus.m_data      = m_data_q;
  assign bus.core_din    = din_q;
  assign bus.core_ds     = ds_q;
  assign bus.core_wr_i   = wr_q;
  assign bus.core_start  = start_q;
  assign bus.core_rd_r   = rd_q;
  assign bus.core_rounds = F_ROUNDS;
  assign bus.core_rst    = rst;
  assign bus.core_clk_en = 1'b1;
  assign bus.core_wr_c   = 1'b0;
  assign bus.core_wr_x   = 1'b0;
  assign bus.core_rd_c   = 1'b0;
  assign bus.busy        = !((state_q == FILL) && (idx_q == 2'd0));

endmodule
